// File: rtl/router_fsm.sv
// Control sequencer for the 1x3 router: decodes the header address, walks the
// register block through its per-packet phases and keeps packet statistics.
module router_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [1:0]       data_in,
  input  logic             parity_done,
  input  logic             low_pkt_valid,
  input  logic             fifo_full,
  input  logic             fifo_empty_0,
  input  logic             fifo_empty_1,
  input  logic             fifo_empty_2,
  input  logic             soft_reset_0,
  input  logic             soft_reset_1,
  input  logic             soft_reset_2,
  output logic             detect_add,
  output logic             lfd_state,
  output logic             ld_state,
  output logic             full_state,
  output logic             laf_state,
  output logic             rst_int_reg,
  output logic             write_enb_reg,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  typedef enum logic [2:0] {DA, WTE, LFD, LD, FFS, LAF, LP, CPE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr_q;
  logic       w_hdr_ok;
  logic       w_hdr_empty;
  logic       w_empty_sel;
  logic       w_srst_sel;
  logic       w_abort;
  logic       w_done;

  // Order: {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy}
  function automatic logic [7:0] decode(input state_t s);
    case (s)
      DA:      decode = 8'b1000_0000;
      WTE:     decode = 8'b0000_0001;
      LFD:     decode = 8'b0100_0011;
      LD:      decode = 8'b0010_0010;
      FFS:     decode = 8'b0001_0001;
      LAF:     decode = 8'b0000_1011;
      LP:      decode = 8'b0000_0011;
      CPE:     decode = 8'b0000_0101;
      default: decode = 8'b1000_0000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Select empty flag / soft reset for the incoming header and the latched address
  always_comb begin
    w_hdr_ok    = pkt_valid && (data_in != 2'd3);
    w_hdr_empty = 1'b0;
    w_empty_sel = 1'b0;
    w_srst_sel  = 1'b0;
    case (data_in)
      2'd0:    w_hdr_empty = fifo_empty_0;
      2'd1:    w_hdr_empty = fifo_empty_1;
      2'd2:    w_hdr_empty = fifo_empty_2;
      default: w_hdr_empty = 1'b0;
    endcase
    case (r_addr_q)
      2'd0:    begin w_empty_sel = fifo_empty_0; w_srst_sel = soft_reset_0; end
      2'd1:    begin w_empty_sel = fifo_empty_1; w_srst_sel = soft_reset_1; end
      2'd2:    begin w_empty_sel = fifo_empty_2; w_srst_sel = soft_reset_2; end
      default: begin w_empty_sel = 1'b0;         w_srst_sel = 1'b0;         end
    endcase
  end

  // Next-state logic; a soft reset on the selected output overrides everything outside DA
  always_comb begin
    w_next = r_state;
    case (r_state)
      DA:      if (w_hdr_ok) w_next = w_hdr_empty ? LFD : WTE; else w_next = DA;
      WTE:     if (w_empty_sel) w_next = LFD; else w_next = WTE;
      LFD:     w_next = LD;
      LD:      if (fifo_full) w_next = FFS;
               else if (!pkt_valid) w_next = LP;
               else w_next = LD;
      FFS:     if (!fifo_full) w_next = LAF; else w_next = FFS;
      LAF:     if (parity_done) w_next = DA;
               else if (low_pkt_valid) w_next = LP;
               else w_next = LD;
      LP:      w_next = CPE;
      CPE:     if (fifo_full) w_next = FFS; else w_next = DA;
      default: w_next = DA;
    endcase
    w_abort = (r_state != DA) && w_srst_sel;
    if (w_abort) begin
      w_next = DA;
    end else begin
      w_next = w_next;
    end
    w_done = !w_abort && (((r_state == CPE) && !fifo_full) ||
                          ((r_state == LAF) && parity_done));
  end

  // State, address latch, registered Moore decodes and saturating counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= DA;
      r_addr_q  <= 2'd0;
      {detect_add, lfd_state, ld_state, full_state,
       laf_state, rst_int_reg, write_enb_reg, busy} <= decode(DA);
      pkt_cnt   <= {CNT_W{1'b0}};
      abort_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if ((r_state == DA) && w_hdr_ok) r_addr_q <= data_in;
      {detect_add, lfd_state, ld_state, full_state,
       laf_state, rst_int_reg, write_enb_reg, busy} <= decode(w_next);
      if (w_done)  pkt_cnt   <= sat_inc(pkt_cnt);
      if (w_abort) abort_cnt <= sat_inc(abort_cnt);
    end
  end

endmodule
